// File: rtl/multiplicador_seq_pkg.sv
// Shared types and defaults for the sequential signed multiplier.
package multiplicador_seq_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiplicador_seq_abs_val.sv
// Two's-complement to unsigned magnitude; -2^(W-1) maps to 2^(W-1).
module abs_val #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] mag
);

    assign mag = x[W-1] ? (~x + W'(1)) : x;

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential signed multiplier: shift-add on operand magnitudes, one multiplier
// bit per clock, product reported as unsigned magnitude plus a sign flag.
module multiplicador_seq
    import multiplicador_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               start,
    output logic [2*WIDTH-1:0] c,
    output logic               neg,
    output logic               done
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [CW-1:0]      cnt_q;
    logic               sign_q;
    logic [2*WIDTH-1:0] c_q;
    logic               neg_q;
    logic               done_q;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    abs_val #(.W(WIDTH)) u_abs_a (.x(A), .mag(a_mag));
    abs_val #(.W(WIDTH)) u_abs_b (.x(B), .mag(b_mag));

    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            c_q      <= '0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                        mplier_q <= b_mag;
                        sign_q   <= A[WIDTH-1] ^ B[WIDTH-1];
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    // Last multiplier bit: publish the result from the final sum.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        c_q     <= acc_d;
                        neg_q   <= sign_q & (acc_d != '0);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign c    = c_q;
    assign neg  = neg_q;
    assign done = done_q;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Self-checking bench for multiplicador_seq: directed table, corner sequences
// and random operands against an integer-arithmetic reference.
module tb_multiplicador_seq;

    logic               clk;
    logic               rst;
    logic signed [7:0]  A;
    logic signed [7:0]  B;
    logic               start;
    logic [15:0]        c;
    logic               neg;
    logic               done;

    int errors = 0;
    int checks = 0;

    multiplicador_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .start(start),
        .c(c), .neg(neg), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] a;
        logic signed [7:0] b;
        int                exp_c;
        int                exp_n;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_mag(input logic signed [7:0] a, input logic signed [7:0] b);
        int p;
        p = int'(a) * int'(b);
        return (p < 0) ? -p : p;
    endfunction

    function automatic int ref_neg(input logic signed [7:0] a, input logic signed [7:0] b);
        return (int'(a) * int'(b) < 0) ? 1 : 0;
    endfunction

    // Raises start with a/b, counts edges after E0 until done, and checks that
    // the previous result is held throughout the calculation.
    task automatic run_op(input string nm, input logic signed [7:0] a,
                          input logic signed [7:0] b, input int ec, input int en);
        logic [15:0] pc;
        logic        pn;
        int          lat;
        int          held;
        pc = c; pn = neg; held = 1;
        A = a; B = b; start = 1'b1;
        step();
        lat = 0;
        while (!done && lat < 20) begin
            if (c !== pc || neg !== pn) held = 0;
            step();
            lat++;
        end
        chk({nm, " latency"}, lat, 8);
        chk({nm, " hold"}, held, 1);
        chk({nm, " c"}, int'(c), ec);
        chk({nm, " neg"}, int'(neg), en);
        chk({nm, " done"}, int'(done), 1);
    endtask

    task automatic drop_start(input string nm, input int ec);
        start = 1'b0;
        step();
        chk({nm, " done cleared"}, int'(done), 0);
        chk({nm, " c kept"}, int'(c), ec);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        logic signed [7:0] ra, rb;

        tbl[0] = '{a: -8'sd128, b: -8'sd128, exp_c: 16384, exp_n: 0};
        tbl[1] = '{a:  8'sd127, b: -8'sd128, exp_c: 16256, exp_n: 1};
        tbl[2] = '{a:  8'sd0,   b: -8'sd5,   exp_c: 0,     exp_n: 0};
        tbl[3] = '{a: -8'sd1,   b: -8'sd1,   exp_c: 1,     exp_n: 0};
        tbl[4] = '{a: -8'sd128, b:  8'sd1,   exp_c: 128,   exp_n: 1};
        tbl[5] = '{a:  8'sd13,  b:  8'sd11,  exp_c: 143,   exp_n: 0};

        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        step();
        step();
        rst = 1'b0;
        chk("reset c", int'(c), 0);
        chk("reset neg", int'(neg), 0);
        chk("reset done", int'(done), 0);

        run_op("2x-4", 8'sd2, -8'sd4, 8, 1);
        drop_start("2x-4", 8);

        do_reset();
        run_op("9x-3", 8'sd9, -8'sd3, 27, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("done held with start", int'(done), 1);
            chk("c held in DONE", int'(c), 27);
        end

        // Reset with start still high: next operation begins without a toggle.
        A = -8'sd9; B = 8'sd3;
        rst = 1'b1;
        step();
        chk("rst c", int'(c), 0);
        chk("rst neg", int'(neg), 0);
        chk("rst done", int'(done), 0);
        rst = 1'b0;
        run_op("restart -9x3", -8'sd9, 8'sd3, 27, 1);
        drop_start("restart", 27);

        foreach (tbl[i]) begin
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp_c, tbl[i].exp_n);
            drop_start($sformatf("tbl%0d", i), tbl[i].exp_c);
        end

        // Abort: reset lands at E4 of a running 5x5.
        A = 8'sd5; B = 8'sd5; start = 1'b1;
        step();
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("abort c", int'(c), 0);
        chk("abort neg", int'(neg), 0);
        chk("abort done", int'(done), 0);
        rst = 1'b0; start = 1'b0;
        repeat (10) step();
        chk("abort idle done", int'(done), 0);
        chk("abort idle c", int'(c), 0);

        // Operands changed mid-calculation are ignored.
        A = 8'sd5; B = 8'sd6; start = 1'b1;
        step();
        step();
        step();
        A = 8'sd1; B = -8'sd2;
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        chk("midcalc latency", n + 2, 8);
        chk("midcalc c", int'(c), 30);
        chk("midcalc neg", int'(neg), 0);
        drop_start("midcalc", 30);

        run_op("-7x-7", -8'sd7, -8'sd7, 49, 0);
        drop_start("-7x-7", 49);

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 7 == 0) rb = 8'sd0;
            run_op($sformatf("rnd %0d*%0d", ra, rb), ra, rb, ref_mag(ra, rb), ref_neg(ra, rb));
            drop_start("rnd", ref_mag(ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
